// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared FSM encoding and defaults for the UART TX scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned C_N_REQ   = 4;
    localparam int unsigned C_TIMEOUT = 2048;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HOLD      = 2'd3
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned f_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin picker, searching upward from last grant + 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int unsigned N_REQ = uart_pkg::C_N_REQ,
    parameter int unsigned IDX_W = uart_pkg::f_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_pos    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_pos = IDX_W'((32'(i_last) + k) % N_REQ);
            if (!o_any && i_req[w_pos]) begin
                o_any           = 1'b1;
                o_idx           = w_pos;
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module      : uart_tx_sched
// Description : Shares one UART transmitter among N_REQ packet requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int unsigned N_REQ   = C_N_REQ,
    parameter  int unsigned TIMEOUT = C_TIMEOUT,
    localparam int unsigned IDX_W   = f_idx_w(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_last,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_busy,
    input  logic               i_tx_done,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_locked,
    output logic               o_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last_grant;
    logic [7:0]       r_data;
    logic             r_last;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0] w_arb_onehot;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic [N_REQ-1:0] w_ready;
    logic [IDX_W-1:0] w_src;
    logic             w_accept;
    logic             w_start;
    logic             w_release;
    logic             w_hold;
    logic             w_timeout;
    logic             w_tmo_hit;
    logic [7:0]       w_bytes [N_REQ];

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
            assign w_bytes[g] = i_req_data[8*g +: 8];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req    (i_req_valid),
        .i_last   (r_last_grant),
        .o_onehot (w_arb_onehot),
        .o_idx    (w_arb_idx),
        .o_any    (w_arb_any)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A done or an accept in the terminal count cycle takes priority over the timeout.
    always_comb begin
        w_next    = r_state;
        w_ready   = '0;
        w_src     = r_owner;
        w_accept  = 1'b0;
        w_start   = 1'b0;
        w_release = 1'b0;
        w_hold    = 1'b0;
        w_timeout = 1'b0;
        w_tmo_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_ready  = w_arb_onehot;
                    w_src    = w_arb_idx;
                    w_accept = 1'b1;
                    w_next   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!i_tx_busy) begin
                    w_start = 1'b1;
                    w_next  = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    if (r_last) begin
                        w_release = 1'b1;
                        w_next    = ST_IDLE;
                    end else begin
                        w_hold = 1'b1;
                        w_next = ST_HOLD;
                    end
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (i_req_valid[r_owner]) begin
                    w_ready[r_owner] = 1'b1;
                    w_accept         = 1'b1;
                    w_next           = ST_LAUNCH;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner      <= '0;
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_data       <= '0;
            r_last       <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_err <= w_timeout;
            if (w_accept) begin
                r_data  <= w_bytes[w_src];
                r_last  <= i_req_last[w_src];
                r_owner <= w_src;
            end
            if (w_release || w_timeout) begin
                r_locked     <= 1'b0;
                r_last_grant <= r_owner;
            end
            if (w_hold) begin
                r_locked <= 1'b1;
            end
            if (w_start || w_hold) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT_DONE || r_state == ST_HOLD) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_req_ready = w_ready;
    assign o_tx_start  = w_start;
    assign o_tx_data   = r_data;
    assign o_grant     = r_owner;
    assign o_locked    = r_locked;
    assign o_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Directed self-checking bench for uart_tx_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_last  = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [1:0]     grant;
    logic           locked;
    logic           err;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_sched #(
        .N_REQ   (N),
        .TIMEOUT (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_busy   (tx_busy),
        .i_tx_done   (tx_done),
        .o_grant     (grant),
        .o_locked    (locked),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] d, input logic l);
        req_valid[k]       = 1'b1;
        req_data[8*k +: 8] = d;
        req_last[k]        = l;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        req_valid = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        cyc();
    endtask

    // Entered in LAUNCH with busy low; returns after the done edge.
    task automatic finish_frame(input logic [7:0] exp_d, input logic [1:0] exp_g);
        #1;
        chk("launch_start", 32'(tx_start), 32'd1);
        chk("launch_data", 32'(tx_data), 32'(exp_d));
        chk("launch_grant", 32'(grant), 32'(exp_g));
        chk("launch_ready", 32'(req_ready), 32'd0);
        cyc();
        chk("wait_start", 32'(tx_start), 32'd0);
        chk("wait_ready", 32'(req_ready), 32'd0);
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
    endtask

    initial begin
        // Reset values
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        cyc();

        // Single byte from requester 0
        set_req(0, 8'h41, 1'b1);
        #1 chk("single_ready", 32'(req_ready), 32'b0001);
        chk("single_nostart", 32'(tx_start), 32'd0);
        cyc();
        req_valid = '0;
        finish_frame(8'h41, 2'd0);
        #1 chk("single_unlocked", 32'(locked), 32'd0);
        set_req(3, 8'h00, 1'b1);
        #1 chk("single_idle", 32'(req_ready), 32'b1000);
        req_valid = '0;

        // Contention: all four valid
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 8'(8'h10 + k), 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1 chk("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
            cyc();
            if (i == 4) req_valid = '0;
            finish_frame(8'(8'h10 + (i % 4)), 2'(i % 4));
        end

        // Packet lock: requester 2 sends two bytes while requester 1 waits
        do_reset();
        set_req(2, 8'h42, 1'b0);
        #1 chk("pkt_first_ready", 32'(req_ready), 32'b0100);
        cyc();
        req_valid = '0;
        set_req(1, 8'h55, 1'b1);
        finish_frame(8'h42, 2'd2);
        #1 chk("pkt_locked", 32'(locked), 32'd1);
        chk("pkt_hold_ready", 32'(req_ready), 32'd0);
        cyc();
        chk("pkt_hold_ready2", 32'(req_ready), 32'd0);
        cyc();
        set_req(2, 8'h43, 1'b1);
        #1 chk("pkt_second_ready", 32'(req_ready), 32'b0100);
        cyc();
        req_valid[2] = 1'b0;
        chk("pkt_locked_launch", 32'(locked), 32'd1);
        finish_frame(8'h43, 2'd2);
        #1 chk("pkt_released", 32'(locked), 32'd0);
        chk("pkt_next_ready", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        finish_frame(8'h55, 2'd1);

        // Busy hold-off for 5 cycles
        do_reset();
        set_req(3, 8'h99, 1'b1);
        tx_busy = 1'b1;
        cyc();
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("busy_nostart", 32'(tx_start), 32'd0);
            chk("busy_data", 32'(tx_data), 32'h99);
            cyc();
        end
        tx_busy = 1'b0;
        finish_frame(8'h99, 2'd3);

        // Timeout with done never pulsed
        do_reset();
        set_req(0, 8'h77, 1'b1);
        cyc();
        req_valid = '0;
        #1 chk("tmo_start", 32'(tx_start), 32'd1);
        cyc();
        for (int j = 0; j < 16; j++) begin
            chk("tmo_noerr", 32'(err), 32'd0);
            cyc();
        end
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_unlocked", 32'(locked), 32'd0);
        cyc();
        chk("tmo_err_pulse", 32'(err), 32'd0);
        set_req(1, 8'h66, 1'b1);
        #1 chk("tmo_idle_ready", 32'(req_ready), 32'b0010);

        // Done in the terminal-count cycle wins over the timeout
        cyc();
        req_valid = '0;
        #1 chk("tie_start", 32'(tx_start), 32'd1);
        cyc();
        for (int j = 0; j < 15; j++) cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk("tie_noerr", 32'(err), 32'd0);
        cyc();
        chk("tie_noerr2", 32'(err), 32'd0);

        // Async reset while a locked packet is in WAIT_DONE
        do_reset();
        set_req(2, 8'hA0, 1'b0);
        cyc();
        req_valid = '0;
        finish_frame(8'hA0, 2'd2);
        set_req(2, 8'hA1, 1'b1);
        #1 chk("ar_hold_ready", 32'(req_ready), 32'b0100);
        cyc();
        req_valid = '0;
        #1 chk("ar_start", 32'(tx_start), 32'd1);
        chk("ar_locked_before", 32'(locked), 32'd1);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("ar_ready", 32'(req_ready), 32'd0);
        chk("ar_start0", 32'(tx_start), 32'd0);
        chk("ar_data", 32'(tx_data), 32'd0);
        chk("ar_grant", 32'(grant), 32'd0);
        chk("ar_locked", 32'(locked), 32'd0);
        chk("ar_err", 32'(err), 32'd0);
        cyc();
        #2 rst = 1'b0;
        cyc();
        chk("ar_noreplay", 32'(tx_start), 32'd0);
        cyc();
        chk("ar_noreplay2", 32'(tx_start), 32'd0);
        set_req(0, 8'h5A, 1'b1);
        set_req(2, 8'hA5, 1'b1);
        #1 chk("ar_req0_wins", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        finish_frame(8'h5A, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
